rr_onehot_sel_arbiter: RTL
==========================

// Module: rr_onehot_sel_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares the 4-input one-hot-select bit mux between
//   four requesters. It produces a registered one-hot grant, which is the
//   mux select, plus the muxed data bit. A grant is held while its owner keeps
//   requesting, up to MAX_HOLD cycles, and then rotates.
//   Sits directly in front of the one-hot mux datapath. sel is never non-one-hot
//   unless it is all-zero.
//
// PARAMETERS
//   MAX_HOLD  8  max consecutive cycles one owner may hold the grant (>=1)
//   CW        $clog2(MAX_HOLD+1)  hold-counter width (derived; do not override)
//
// PORTS
//   clk        in   1   single clock, rising edge
//   reset_n    in   1   asynchronous, active-low reset
//   req        in   4   request per requester, level-sensitive
//   in         in   4   data bit per requester
//   sel        out  4   registered one-hot grant / mux select, 0 = no owner
//   gnt_valid  out  1   registered, equals |sel
//   out        out  1   combinational, |(sel & in); 0 when sel==0
//   hold_cnt   out  CW  registered, cycles the current owner has held the grant
//
// BEHAVIOUR
//   Reset (async assert, sync-to-clk deassert by the system):
//     sel=0, gnt_valid=0, hold_cnt=0, last=3, state=IDLE.
//     last=3 means requester 0 has top priority first.
//   State machine, 2 states:
//     IDLE: sel=0.
//       If req!=0, grant the first set req scanning last+1, last+2, ... mod 4.
//       Next edge: sel=onehot(winner), hold_cnt=1, last=winner, go to GRANT.
//     GRANT, owner o: release when req[o]==0 OR hold_cnt==MAX_HOLD.
//       No release: sel holds, hold_cnt+=1.
//       Release with other reqs pending (req & ~onehot(o) != 0):
//         - next owner = first set bit after o in RR order, excluding o
//         - switch on the same edge, no bubble
//         - hold_cnt=1, last=new owner
//       Release by expiry with only o requesting: re-grant o, hold_cnt=1.
//       Release by drop with no other reqs: sel=0, hold_cnt=0, go to IDLE.
//         last stays o.
//   Latency: req to sel is 1 cycle from IDLE. Owner change is 1 cycle after
//     the release condition is seen.
//   out is a zero-latency mux of in by the current sel.
//   Invariants: $onehot0(sel) always. hold_cnt never exceeds MAX_HOLD.
//     hold_cnt==0 iff sel==0.
//   Fairness: with all four requesting continuously, sel rotates 0,1,2,3,0...
//     Each grant lasts exactly MAX_HOLD cycles.
//   MAX_HOLD=1: grant rotates every cycle whenever others are requesting.
//   Requests not granted are not latched. A req pulse dropped before grant
//     is lost.
//   Reset mid-grant: sel drops to 0 immediately (async). Priority restarts at
//     requester 0.
//
// TESTING
//   1 Reset then req=4'b0110 held, MAX_HOLD=8 -> cycle+1 sel=0010, hold_cnt=1.
//     Held 8 cycles, then sel=0100.
//   2 req=4'b1111 constant, MAX_HOLD=2 -> sel sequence
//     0001,0001,0010,0010,0100,0100,1000,1000,0001. Never two bits set.
//   3 Owner 1 drops req[1] at cycle 3 with req[3]=1 -> next edge sel=1000,
//     hold_cnt=1, no zero cycle.
//   4 Only req[2] held 20 cycles, MAX_HOLD=8 -> sel stays 0100 throughout.
//     hold_cnt counts 1..8, 1..8, 1..4.
//   5 sel=0100, in=4'b0100 then in=4'b1011 -> out=1 then out=0 in the same
//     cycle. With req=0 and sel=0, out=0 for any in.
//   6 reset_n low mid-grant, sel=1000 -> sel=0 and gnt_valid=0 before the next
//     edge. After release with req=4'b1001: sel=0001.

Source files
------------

// File: rtl/rr_onehot_sel_arbiter.sv
// Round-robin arbiter driving a 4-input one-hot-select bit mux.
// Registered one-hot grant with a per-owner hold limit; muxed data bit is combinational.

module rr_onehot_sel_lane (
  input  logic sel_bit,
  input  logic in_bit,
  output logic out_bit
);
  assign out_bit = sel_bit & in_bit;
endmodule

module rr_onehot_sel_arbiter #(
  parameter  int MAX_HOLD = 8,
  localparam int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    req,
  input  logic [3:0]    in,
  output logic [3:0]    sel,
  output logic          gnt_valid,
  output logic          out,
  output logic [CW-1:0] hold_cnt
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [3:0]     sel_q, sel_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]     last_q, last_d;

  logic           release_c;
  logic [3:0]     others_c;
  logic [1:0]     winner_c;
  logic [NUM_LANES-1:0] lane_out;

  // First set bit scanning base+1, base+2, ... wrapping; base itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int i = 1; i <= NUM_LANES; i++) begin
      idx = base + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    release_c  = 1'b0;
    others_c   = req & ~(4'b0001 << last_q);
    winner_c   = last_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          winner_c   = rr_pick(req, last_q);
          sel_d      = 4'b0001 << winner_c;
          hold_cnt_d = CW'(1);
          last_d     = winner_c;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // In GRANT the owner is always last_q.
        release_c = !req[last_q] || (hold_cnt_q == CW'(MAX_HOLD));
        if (!release_c) begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end else if (|others_c) begin
          winner_c   = rr_pick(others_c, last_q);
          sel_d      = 4'b0001 << winner_c;
          hold_cnt_d = CW'(1);
          last_d     = winner_c;
        end else if (req[last_q]) begin
          hold_cnt_d = CW'(1);
        end else begin
          sel_d      = 4'b0000;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_valid_d = |sel_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      last_q      <= 2'd3;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gnt_valid_q <= gnt_valid_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rr_onehot_sel_lane u_lane (
      .sel_bit (sel_q[g]),
      .in_bit  (in[g]),
      .out_bit (lane_out[g])
    );
  end

  assign sel       = sel_q;
  assign gnt_valid = gnt_valid_q;
  assign hold_cnt  = hold_cnt_q;
  assign out       = |lane_out;

endmodule
